// File: rtl/axi3_pkg.sv
// Shared AXI3 encodings, engine state types and the read-beat payload for the
// lightweight-bridge register responder.
package axi3_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE,
    R_DATA
  } rd_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  // Only FIXED/INCR with 4-byte beats are served; anything else errors the burst.
  function automatic logic burst_illegal(input logic [1:0] burst, input logic [2:0] size);
    return !((burst == BURST_FIXED) || (burst == BURST_INCR)) || (size != SIZE_4B);
  endfunction

endpackage

// File: rtl/axi3_burst_addr.sv
// Per-direction burst tracker: beat counter, next address, range check, last flag.
// LOOKAHEAD exposes the beat that becomes current after this edge instead of the current one.
module axi3_burst_addr
  import axi3_pkg::*;
#(
  parameter int unsigned ADDR_W    = 21,
  parameter int unsigned NREGS     = 16,
  parameter bit          LOOKAHEAD = 1'b0,
  parameter int unsigned IDX_W     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_len,
  input  logic [1:0]        i_burst,
  input  logic [2:0]        i_size,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_oor,
  output logic              o_err,
  output logic              o_last
);

  // One spare bit keeps an INCR carry past the window out of range instead of wrapping.
  localparam int unsigned AW = ADDR_W + 1;

  logic [AW-1:0] r_addr, w_up_addr, w_nxt_addr, w_sel_addr;
  logic [3:0]    r_beat, r_len, w_up_beat, w_up_len, w_sel_beat, w_sel_len;
  logic          r_err, r_fixed, w_up_err, w_up_fixed, w_sel_err;

  assign w_nxt_addr = r_fixed ? r_addr : r_addr + AW'(4);

  always_comb begin
    w_up_addr  = r_addr;
    w_up_beat  = r_beat;
    w_up_len   = r_len;
    w_up_err   = r_err;
    w_up_fixed = r_fixed;
    if (i_load) begin
      w_up_addr  = AW'(i_addr);
      w_up_beat  = 4'd0;
      w_up_len   = i_len;
      w_up_err   = burst_illegal(i_burst, i_size);
      w_up_fixed = (i_burst == BURST_FIXED);
    end else if (i_adv) begin
      w_up_addr  = w_nxt_addr;
      w_up_beat  = r_beat + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_beat  <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
      r_fixed <= 1'b0;
    end else if (i_load || i_adv) begin
      r_addr  <= w_up_addr;
      r_beat  <= w_up_beat;
      r_len   <= w_up_len;
      r_err   <= w_up_err;
      r_fixed <= w_up_fixed;
    end
  end

  if (LOOKAHEAD) begin : g_la
    assign w_sel_addr = w_up_addr;
    assign w_sel_beat = w_up_beat;
    assign w_sel_len  = w_up_len;
    assign w_sel_err  = w_up_err;
  end else begin : g_cur
    assign w_sel_addr = r_addr;
    assign w_sel_beat = r_beat;
    assign w_sel_len  = r_len;
    assign w_sel_err  = r_err;
  end

  assign o_idx  = w_sel_addr[IDX_W+1:2];
  assign o_oor  = |w_sel_addr[AW-1:IDX_W+2];
  assign o_err  = w_sel_err;
  assign o_last = (w_sel_beat == w_sel_len);

endmodule

// File: rtl/axi3_lw_reg_slave.sv
// AXI3 responder for the HPS-to-FPGA lightweight bridge terminating bursts into a
// bank of 32-bit registers, with independent write and read engines.
module axi3_lw_reg_slave
  import axi3_pkg::*;
#(
  parameter int unsigned ID_W   = 12,
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned NREGS  = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_W-1:0]       awid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [3:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [ID_W-1:0]       wid,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ID_W-1:0]       arid,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ID_W-1:0]       rid,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic [NREGS*32-1:0]   regs,
  output logic [NREGS-1:0]      wr_pulse
);

  localparam int unsigned IDX_W = $clog2(NREGS);

  logic [31:0]      r_regs [NREGS];
  logic [NREGS-1:0] r_wr_pulse;

  wr_state_e        r_wstate, w_wstate_nxt;
  logic             r_awready, w_awready_nxt, r_wready, w_wready_nxt;
  logic             r_bvalid, w_bvalid_nxt, r_werr, w_werr_nxt;
  logic [1:0]       r_bresp, w_bresp_nxt;
  logic [ID_W-1:0]  r_bid;

  rd_state_e        r_rstate, w_rstate_nxt;
  logic             r_arready, w_arready_nxt, r_rvalid, w_rvalid_nxt;
  rbeat_t           r_rbeat, w_rbeat_nxt, w_rbeat_ld;
  logic [ID_W-1:0]  r_rid;

  logic             w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic             w_wbeat_ok, w_reg_we;
  logic [IDX_W-1:0] w_wa_idx, w_ra_idx;
  logic             w_wa_oor, w_wa_err, w_wa_last, w_ra_oor, w_ra_err, w_ra_last;

  assign w_aw_hs = awvalid & r_awready;
  assign w_w_hs  = wvalid & r_wready;
  assign w_b_hs  = r_bvalid & bready;
  assign w_ar_hs = arvalid & r_arready;
  assign w_r_hs  = r_rvalid & rready;

  axi3_burst_addr #(
    .ADDR_W(ADDR_W), .NREGS(NREGS), .LOOKAHEAD(1'b0), .IDX_W(IDX_W)
  ) u_wr_addr (
    .clk(CLK), .rst_n(RST_N), .i_load(w_aw_hs), .i_adv(w_w_hs),
    .i_addr(awaddr), .i_len(awlen), .i_burst(awburst), .i_size(awsize),
    .o_idx(w_wa_idx), .o_oor(w_wa_oor), .o_err(w_wa_err), .o_last(w_wa_last)
  );

  // Read side looks one beat ahead so the output registers load the upcoming beat.
  axi3_burst_addr #(
    .ADDR_W(ADDR_W), .NREGS(NREGS), .LOOKAHEAD(1'b1), .IDX_W(IDX_W)
  ) u_rd_addr (
    .clk(CLK), .rst_n(RST_N), .i_load(w_ar_hs), .i_adv(w_r_hs & ~r_rbeat.last),
    .i_addr(araddr), .i_len(arlen), .i_burst(arburst), .i_size(arsize),
    .o_idx(w_ra_idx), .o_oor(w_ra_oor), .o_err(w_ra_err), .o_last(w_ra_last)
  );

  assign w_wbeat_ok = ~w_wa_oor & ~w_wa_err;
  assign w_reg_we   = w_w_hs & w_wbeat_ok;

  // Write engine next-state and registered handshake outputs.
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_awready_nxt = r_awready;
    w_wready_nxt  = r_wready;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_werr_nxt    = r_werr;
    case (r_wstate)
      W_IDLE: if (w_aw_hs) begin
        w_wstate_nxt  = W_DATA;
        w_awready_nxt = 1'b0;
        w_wready_nxt  = 1'b1;
        w_werr_nxt    = 1'b0;
      end
      W_DATA: if (w_w_hs) begin
        if (!w_wbeat_ok || (wid != r_bid) || (wlast != w_wa_last)) w_werr_nxt = 1'b1;
        if (wlast || w_wa_last) begin
          w_wstate_nxt = W_RESP;
          w_wready_nxt = 1'b0;
          w_bvalid_nxt = 1'b1;
          w_bresp_nxt  = w_werr_nxt ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: if (w_b_hs) begin
        w_wstate_nxt  = W_IDLE;
        w_bvalid_nxt  = 1'b0;
        w_awready_nxt = 1'b1;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_werr    <= 1'b0;
      r_bid     <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
      r_werr    <= w_werr_nxt;
      if (w_aw_hs) r_bid <= awid;
    end
  end

  // Register bank: byte-enable merge and one-cycle write strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_reg_we) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) r_regs[w_wa_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
        if (|wstrb) r_wr_pulse[w_wa_idx] <= 1'b1;
      end
    end
  end

  assign w_rbeat_ld.data = (w_ra_oor || w_ra_err) ? 32'd0 : r_regs[w_ra_idx];
  assign w_rbeat_ld.resp = (w_ra_oor || w_ra_err) ? RESP_SLVERR : RESP_OKAY;
  assign w_rbeat_ld.last = w_ra_last;

  // Read engine next-state; beat registers hold while the master stalls.
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rbeat_nxt   = r_rbeat;
    case (r_rstate)
      R_IDLE: if (w_ar_hs) begin
        w_rstate_nxt  = R_DATA;
        w_arready_nxt = 1'b0;
        w_rvalid_nxt  = 1'b1;
        w_rbeat_nxt   = w_rbeat_ld;
      end
      R_DATA: if (w_r_hs) begin
        if (r_rbeat.last) begin
          w_rstate_nxt  = R_IDLE;
          w_rvalid_nxt  = 1'b0;
          w_arready_nxt = 1'b1;
        end else begin
          w_rbeat_nxt   = w_rbeat_ld;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rbeat   <= '0;
      r_rid     <= '0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rbeat   <= w_rbeat_nxt;
      if (w_ar_hs) r_rid <= arid;
    end
  end

  for (genvar k = 0; k < NREGS; k++) begin : g_flat
    assign regs[32*k +: 32] = r_regs[k];
  end

  assign awready  = r_awready;
  assign wready   = r_wready;
  assign bvalid   = r_bvalid;
  assign bresp    = r_bresp;
  assign bid      = r_bid;
  assign arready  = r_arready;
  assign rvalid   = r_rvalid;
  assign rid      = r_rid;
  assign rdata    = r_rbeat.data;
  assign rresp    = r_rbeat.resp;
  assign rlast    = r_rbeat.last;
  assign wr_pulse = r_wr_pulse;

endmodule
